// File: rtl/seg_shift_rx_pkg.sv
// Shared constants and FSM encoding for the serial display link receiver.
// Frame widths cover the seven-segment chain and the LED bar.
package seg_shift_rx_pkg;

  localparam int SEG_FRAME_W = 64;
  localparam int LED_FRAME_W = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_OVER  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/seg_shift_rx_sync.sv
// Two-flop synchronizer for one link wire, plus a history flop.
// The history flop turns the synced level into a one-cycle rising-edge strobe.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic meta;
  logic stable;
  logic hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      stable <= 1'b0;
      hist   <= 1'b0;
    end else begin
      meta   <= din;
      stable <= meta;
      hist   <= stable;
    end
  end

  assign sync = stable;
  assign rise = stable & ~hist;

endmodule

// File: rtl/seg_shift_rx.sv
// Receiver for the serial display link: oversamples ser_clk/ser_do/ser_pen,
// rebuilds each MSB-first frame and reports good frames or length errors on latch.
module seg_shift_rx
  import seg_shift_rx_pkg::*;
#(
  parameter int FRAME_W = SEG_FRAME_W,
  parameter int CNT_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ser_clk,
  input  logic               ser_do,
  input  logic               ser_pen,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_valid,
  output logic               len_err,
  output logic [CNT_W-1:0]   bit_count,
  output logic               busy
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FRAME_W);

  logic clk_rise;
  logic pen_rise;
  logic do_sync;
  logic clk_sync_unused;
  logic pen_sync_unused;
  logic do_rise_unused;

  sync_edge_det u_sync_clk (.clk(clk), .rst(rst), .din(ser_clk), .sync(clk_sync_unused), .rise(clk_rise));
  sync_edge_det u_sync_do  (.clk(clk), .rst(rst), .din(ser_do),  .sync(do_sync),         .rise(do_rise_unused));
  sync_edge_det u_sync_pen (.clk(clk), .rst(rst), .din(ser_pen), .sync(pen_sync_unused), .rise(pen_rise));

  rx_state_t          state;
  rx_state_t          state_next;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] shreg_next;
  logic [CNT_W-1:0]   count_next;

  // Shift/count step; the latch decision below looks at these post-shift values
  // so a ser_clk rise coincident with the latch still counts toward the frame.
  always_comb begin
    shreg_next = shreg;
    count_next = bit_count;
    state_next = state;
    if (clk_rise) begin
      shreg_next = {shreg[FRAME_W-2:0], do_sync};
      case (state)
        RX_IDLE: begin
          state_next = RX_SHIFT;
          count_next = CNT_W'(1);
        end
        RX_SHIFT: begin
          if (bit_count == FULL_COUNT) state_next = RX_OVER;
          else                         count_next = bit_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RX_IDLE;
      shreg       <= '0;
      bit_count   <= '0;
      busy        <= 1'b0;
      frame       <= '0;
      frame_valid <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      shreg       <= shreg_next;
      frame_valid <= 1'b0;
      len_err     <= 1'b0;
      if (pen_rise) begin
        state     <= RX_IDLE;
        bit_count <= '0;
        busy      <= 1'b0;
        if (state_next == RX_SHIFT && count_next == FULL_COUNT) begin
          frame       <= shreg_next;
          frame_valid <= 1'b1;
        end else begin
          len_err <= 1'b1;
        end
      end else begin
        state     <= state_next;
        bit_count <= count_next;
        busy      <= (state_next != RX_IDLE);
      end
    end
  end

endmodule

// File: tb/tb_seg_shift_rx.sv
// Bench for seg_shift_rx: a 64-bit and a 16-bit receiver share one link and are
// checked every cycle against a bit-list model plus a few literal expectations.
module tb_seg_shift_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ser_clk = 1'b0;
  logic        ser_do = 1'b0;
  logic        ser_pen = 1'b0;

  logic [63:0] seg_frame;
  logic        seg_valid, seg_err, seg_busy;
  logic [6:0]  seg_count;
  logic [15:0] led_frame;
  logic        led_valid, led_err, led_busy;
  logic [4:0]  led_count;

  seg_shift_rx #(.FRAME_W(64), .CNT_W(7)) u_seg (
    .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_do(ser_do), .ser_pen(ser_pen),
    .frame(seg_frame), .frame_valid(seg_valid), .len_err(seg_err),
    .bit_count(seg_count), .busy(seg_busy)
  );

  seg_shift_rx #(.FRAME_W(16), .CNT_W(5)) u_led (
    .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_do(ser_do), .ser_pen(ser_pen),
    .frame(led_frame), .frame_valid(led_valid), .len_err(led_err),
    .bit_count(led_count), .busy(led_busy)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: pin samples taken at each clk edge; an event becomes visible in the
  // outputs when it is two samples old (two sync stages, then registered).
  int          fw [2] = '{64, 16};
  logic [63:0] mask [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_FFFF};
  logic [3:0]  clk_h, do_h, pen_h;
  logic [63:0] acc [2];
  int          nbits [2];
  logic [63:0] exp_frame [2];
  logic        exp_valid [2];
  logic        exp_err [2];
  int          exp_count [2];
  logic        exp_busy [2];
  int          valid_cnt [2];
  int          err_cnt [2];

  task automatic model_clear();
    clk_h = '0; do_h = '0; pen_h = '0;
    for (int i = 0; i < 2; i++) begin
      acc[i] = '0; nbits[i] = 0; exp_frame[i] = '0;
      exp_valid[i] = 1'b0; exp_err[i] = 1'b0; exp_count[i] = 0; exp_busy[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic cr, pr, d;
    clk_h = {clk_h[2:0], ser_clk};
    do_h  = {do_h[2:0], ser_do};
    pen_h = {pen_h[2:0], ser_pen};
    cr = clk_h[2] & ~clk_h[3];
    pr = pen_h[2] & ~pen_h[3];
    d  = do_h[2];
    for (int i = 0; i < 2; i++) begin
      exp_valid[i] = 1'b0;
      exp_err[i]   = 1'b0;
      if (cr) begin
        acc[i]   = {acc[i][62:0], d};
        nbits[i] = nbits[i] + 1;
      end
      if (pr) begin
        if (nbits[i] == fw[i]) begin
          exp_frame[i] = acc[i] & mask[i];
          exp_valid[i] = 1'b1;
        end else begin
          exp_err[i] = 1'b1;
        end
        nbits[i] = 0;
      end
      exp_count[i] = (nbits[i] > fw[i]) ? fw[i] : nbits[i];
      exp_busy[i]  = (nbits[i] != 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else     model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("seg_frame", seg_frame, exp_frame[0]);
      chk("seg_valid", 64'(seg_valid), 64'(exp_valid[0]));
      chk("seg_err",   64'(seg_err),   64'(exp_err[0]));
      chk("seg_count", 64'(seg_count), 64'(exp_count[0]));
      chk("seg_busy",  64'(seg_busy),  64'(exp_busy[0]));
      chk("led_frame", 64'(led_frame), exp_frame[1]);
      chk("led_valid", 64'(led_valid), 64'(exp_valid[1]));
      chk("led_err",   64'(led_err),   64'(exp_err[1]));
      chk("led_count", 64'(led_count), 64'(exp_count[1]));
      chk("led_busy",  64'(led_busy),  64'(exp_busy[1]));
      if (seg_valid) valid_cnt[0]++;
      if (led_valid) valid_cnt[1]++;
      if (seg_err)   err_cnt[0]++;
      if (led_err)   err_cnt[1]++;
    end
  end

  task automatic send_bit(input logic b);
    ser_clk = 1'b0;
    ser_do  = b;
    repeat (3) tick();
    ser_clk = 1'b1;
    repeat (3) tick();
  endtask

  task automatic send_word(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic pulse_pen();
    ser_clk = 1'b0;
    repeat (3) tick();
    ser_pen = 1'b1;
    repeat (3) tick();
    ser_pen = 1'b0;
    repeat (3) tick();
  endtask

  task automatic settle();
    repeat (5) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_frame"}, seg_frame, 64'h0);
    chk({tag, "_count"}, 64'(seg_count), 64'h0);
    chk({tag, "_busy"},  64'(seg_busy), 64'h0);
    chk({tag, "_valid"}, 64'(seg_valid), 64'h0);
    chk({tag, "_err"},   64'(seg_err), 64'h0);
    chk({tag, "_led_frame"}, 64'(led_frame), 64'h0);
  endtask

  int v0, e0, lv0, le0;
  logic [63:0] good_word  = 64'hF0E1_D2C3_B4A5_9687;
  logic [63:0] coin_word  = 64'h0123_4567_89AB_CDEF;

  initial begin
    model_clear();
    for (int i = 0; i < 2; i++) begin valid_cnt[i] = 0; err_cnt[i] = 0; end
    #2;
    check_reset_outputs("reset_init");
    repeat (2) tick();
    rst = 1'b0;
    settle();

    // Good 64-bit frame; the LED receiver sees it as too long
    v0 = valid_cnt[0]; e0 = err_cnt[0]; le0 = err_cnt[1];
    send_word(good_word, 64);
    pulse_pen();
    settle();
    chk("lit_good_frame", seg_frame, 64'hF0E1_D2C3_B4A5_9687);
    chk("lit_good_valid_pulses", 64'(valid_cnt[0] - v0), 64'd1);
    chk("lit_good_no_err", 64'(err_cnt[0] - e0), 64'd0);
    chk("lit_good_count_back", 64'(seg_count), 64'd0);
    chk("lit_led_long_err", 64'(err_cnt[1] - le0), 64'd1);
    $display("good frame: frame=%h valid_pulses=%0d", seg_frame, valid_cnt[0] - v0);

    // Short frame: 63 bits
    v0 = valid_cnt[0]; e0 = err_cnt[0];
    send_word(64'h1111_2222_3333_4444, 63);
    pulse_pen();
    settle();
    chk("lit_short_err", 64'(err_cnt[0] - e0), 64'd1);
    chk("lit_short_no_valid", 64'(valid_cnt[0] - v0), 64'd0);
    chk("lit_short_frame_kept", seg_frame, 64'hF0E1_D2C3_B4A5_9687);
    $display("short frame: err_pulses=%0d frame=%h", err_cnt[0] - e0, seg_frame);

    // Long frame: 70 bits, count saturates at 64
    e0 = err_cnt[0];
    send_word(64'hDEAD_BEEF_CAFE_F00D, 64);
    send_word(64'h3F, 6);
    settle();
    chk("lit_long_count_sat", 64'(seg_count), 64'd64);
    chk("lit_long_busy", 64'(seg_busy), 64'd1);
    pulse_pen();
    settle();
    chk("lit_long_err", 64'(err_cnt[0] - e0), 64'd1);
    chk("lit_long_frame_kept", seg_frame, 64'hF0E1_D2C3_B4A5_9687);
    $display("long frame: err_pulses=%0d count_after=%0d", err_cnt[0] - e0, seg_count);

    // Coincident last ser_clk rise and ser_pen rise
    v0 = valid_cnt[0]; e0 = err_cnt[0];
    send_word(coin_word >> 1, 63);
    ser_clk = 1'b0;
    ser_do  = coin_word[0];
    repeat (3) tick();
    ser_clk = 1'b1;
    ser_pen = 1'b1;
    repeat (3) tick();
    ser_clk = 1'b0;
    ser_pen = 1'b0;
    repeat (3) tick();
    settle();
    chk("lit_coin_frame", seg_frame, 64'h0123_4567_89AB_CDEF);
    chk("lit_coin_valid", 64'(valid_cnt[0] - v0), 64'd1);
    chk("lit_coin_no_err", 64'(err_cnt[0] - e0), 64'd0);
    $display("coincident edges: frame=%h", seg_frame);

    // Async reset after 10 bits of a frame
    send_word(64'h2AA, 10);
    settle();
    chk("lit_pre_reset_count", 64'(seg_count), 64'd10);
    rst = 1'b1;
    ser_clk = 1'b0;
    ser_pen = 1'b0;
    ser_do  = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    model_clear();
    repeat (2) tick();
    rst = 1'b0;
    settle();
    v0 = valid_cnt[0];
    send_word(good_word, 64);
    pulse_pen();
    settle();
    chk("lit_post_reset_frame", seg_frame, 64'hF0E1_D2C3_B4A5_9687);
    chk("lit_post_reset_valid", 64'(valid_cnt[0] - v0), 64'd1);
    $display("reset mid-frame: recovered frame=%h", seg_frame);

    // 16-bit LED frames back to back
    lv0 = valid_cnt[1];
    send_word(64'hA55A, 16);
    pulse_pen();
    chk("lit_led_a55a", 64'(led_frame), 64'h0000_0000_0000_A55A);
    send_word(64'h1234, 16);
    pulse_pen();
    settle();
    chk("lit_led_1234", 64'(led_frame), 64'h0000_0000_0000_1234);
    chk("lit_led_valid_pulses", 64'(valid_cnt[1] - lv0), 64'd2);
    $display("led frames: last=%h valid_pulses=%0d", led_frame, valid_cnt[1] - lv0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
